dsram_responder: RTL and testbench

Responder end of the CPU data-side sram-like port: accepts the core's `data_sram_*` requests, drives `data_stall` until each access completes, and returns read data. It forwards each access exactly once to a downstream split-handshake memory port (addr_ok/data_ok), the same port the cache/AXI bridge exposes. It sits between the core's data port and the data cache, and holds a completed result stable while the pipeline remains frozen by other stall sources.

---
 rtl/dsram_responder.sv | 127 ++++++++++++
 tb/tb_dsram_responder.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/dsram_responder.sv
// Responder for the CPU data-side sram-like port, forwarding each access once to a split addr_ok/data_ok memory port.
// Optional build macro: DSRAM_FAST_DONE_EN (release the stall and bypass read data on the mem_data_ok cycle).
module dsram_responder (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_sram_en,
  input  logic [31:0] data_sram_addr,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic        data_stall,
  input  logic        longest_stall,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t      state_r;
  logic [31:0] rdata_r;
  logic        stall_s;
  logic [31:0] rdata_s;

  // Access sequencer; latched request fields stay frozen until the next access is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      mem_req   <= 1'b0;
      mem_wr    <= 1'b0;
      mem_wstrb <= 4'd0;
      mem_addr  <= 32'd0;
      mem_wdata <= 32'd0;
      rdata_r   <= 32'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (data_sram_en) begin
            mem_addr  <= data_sram_addr;
            mem_wstrb <= data_sram_wen;
            mem_wdata <= data_sram_wdata;
            mem_wr    <= |data_sram_wen;
            mem_req   <= 1'b1;
            state_r   <= ADDR;
          end else begin
            state_r   <= IDLE;
          end
        end
        ADDR: begin
          if (mem_addr_ok) begin
            mem_req <= 1'b0;
            state_r <= DATA;
          end else begin
            state_r <= ADDR;
          end
        end
        DATA: begin
          // Stores capture too; the core simply ignores the value.
          if (mem_data_ok) begin
            rdata_r <= mem_rdata;
`ifdef DSRAM_FAST_DONE_EN
            state_r <= longest_stall ? DONE : IDLE;
`else
            state_r <= DONE;
`endif
          end else begin
            state_r <= DATA;
          end
        end
        DONE: begin
          // The core keeps presenting the finished request while frozen; it must not be reissued.
          if (!longest_stall) begin
            state_r <= IDLE;
          end else begin
            state_r <= DONE;
          end
        end
        default: begin
          mem_req <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  // Freeze the core from request acceptance until the result is available.
  always_comb begin
    stall_s = 1'b0;
    case (state_r)
      IDLE:    stall_s = data_sram_en;
      ADDR:    stall_s = 1'b1;
`ifdef DSRAM_FAST_DONE_EN
      DATA:    stall_s = !mem_data_ok;
`else
      DATA:    stall_s = 1'b1;
`endif
      DONE:    stall_s = 1'b0;
      default: stall_s = 1'b0;
    endcase
  end

  // Read data returned to the core.
  always_comb begin
    rdata_s = rdata_r;
`ifdef DSRAM_FAST_DONE_EN
    if ((state_r == DATA) && mem_data_ok) begin
      rdata_s = mem_rdata;
    end else begin
      rdata_s = rdata_r;
    end
`endif
  end

  assign data_stall      = stall_s;
  assign data_sram_rdata = rdata_s;

endmodule

// File: tb/tb_dsram_responder.sv
// Scoreboard bench for dsram_responder: directed accesses push expected handshakes/results, a monitor pops and compares.
module tb_dsram_responder;

`ifdef DSRAM_FAST_DONE_EN
  localparam int FAST = 1;
`else
  localparam int FAST = 0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        data_sram_en;
  logic [31:0] data_sram_addr;
  logic [3:0]  data_sram_wen;
  logic [31:0] data_sram_wdata;
  logic [31:0] data_sram_rdata;
  logic        data_stall;
  logic        longest_stall;
  logic        other_stall;
  logic        mem_req;
  logic        mem_wr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_addr_ok;
  logic        mem_data_ok;
  logic [31:0] mem_rdata;

  typedef struct packed {
    logic [31:0] addr;
    logic        wr;
    logic [3:0]  strb;
    logic [31:0] wdata;
  } req_t;

  req_t        req_q[$];
  logic [31:0] resp_q[$];
  int          total = 0;
  int          bad = 0;
  logic        prev_stall = 1'b0;
  req_t        mon_req;
  logic [31:0] mon_resp;

  always #5 clk = ~clk;

  assign longest_stall = data_stall | other_stall;

  dsram_responder dut (
    .clk             (clk),
    .rst             (rst),
    .data_sram_en    (data_sram_en),
    .data_sram_addr  (data_sram_addr),
    .data_sram_wen   (data_sram_wen),
    .data_sram_wdata (data_sram_wdata),
    .data_sram_rdata (data_sram_rdata),
    .data_stall      (data_stall),
    .longest_stall   (longest_stall),
    .mem_req         (mem_req),
    .mem_wr          (mem_wr),
    .mem_wstrb       (mem_wstrb),
    .mem_addr        (mem_addr),
    .mem_wdata       (mem_wdata),
    .mem_addr_ok     (mem_addr_ok),
    .mem_data_ok     (mem_data_ok),
    .mem_rdata       (mem_rdata)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: compares each accepted downstream request and each completed access against the queues.
  always @(negedge clk) begin
    #2;
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (mem_req && mem_addr_ok) begin
        if (req_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_req: got addr %h expected no request", mem_addr);
        end else begin
          mon_req = req_q.pop_front();
          check("req_addr", mem_addr, mon_req.addr);
          check("req_wr", 32'(mem_wr), 32'(mon_req.wr));
          check("req_strb", 32'(mem_wstrb), 32'(mon_req.strb));
          check("req_wdata", mem_wdata, mon_req.wdata);
        end
      end
      if (prev_stall && !data_stall) begin
        if (resp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_done: got rdata %h expected no completion", data_sram_rdata);
        end else begin
          mon_resp = resp_q.pop_front();
          check("rdata", data_sram_rdata, mon_resp);
        end
      end
      prev_stall = data_stall;
    end
  end

  task automatic access(input logic [31:0] a, input logic [3:0] w, input logic [31:0] wd,
                        input logic [31:0] rd, input int adly, input int ddly,
                        input int hold, input bit flush);
    int   reqc = 0;
    int   dcnt = 0;
    int   stallc = 0;
    int   cyc = 0;
    bit   acc = 1'b0;
    bit   got = 1'b0;
    bit   done = 1'b0;
    bit   acc_next;
    req_t e;
    e.addr = a; e.wr = |w; e.strb = w; e.wdata = wd;
    req_q.push_back(e);
    resp_q.push_back(rd);
    @(negedge clk);
    data_sram_en = 1'b1; data_sram_addr = a; data_sram_wen = w; data_sram_wdata = wd;
    other_stall = 1'b0;
    while (!done && cyc < 60) begin
      if (cyc > 0) @(negedge clk);
      mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = 32'hFFFF_FFFF; acc_next = 1'b0;
      if (acc && !got) begin
        if (flush && dcnt == 0) data_sram_en = 1'b0;
        if (dcnt == ddly) begin
          mem_data_ok = 1'b1; mem_rdata = rd; got = 1'b1;
        end
        dcnt++;
      end else if (mem_req) begin
        reqc++;
        if (reqc > adly) begin
          mem_addr_ok = 1'b1; acc_next = 1'b1;
        end else begin
          mem_data_ok = 1'b1; mem_rdata = 32'hBAD0_BAD0;
        end
      end
      #1;
      if (data_stall) stallc++;
      else begin
        done = 1'b1;
        if (hold > 0) other_stall = 1'b1;
      end
      if (acc_next) acc = 1'b1;
      cyc++;
    end
    check("done_in_budget", 32'(done), 32'd1);
    check("stall_cycles", 32'(stallc), 32'(3 + adly + ddly - FAST));
    check("req_cycles", 32'(reqc), 32'(adly + 1));
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = 32'hFFFF_FFFF;
      if (h == hold - 1) other_stall = 1'b0;
      #1;
      check("hold_req", 32'(mem_req), 32'd0);
      check("hold_stall", 32'(data_stall), 32'd0);
      check("hold_rdata", data_sram_rdata, rd);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      data_sram_en = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b0;
      other_stall = 1'b0; mem_rdata = 32'hFFFF_FFFF;
      #1;
      check("idle_req", 32'(mem_req), 32'd0);
      check("idle_stall", 32'(data_stall), 32'd0);
    end
  endtask

  initial begin
    rst = 1'b1;
    data_sram_en = 1'b0; data_sram_addr = 32'd0; data_sram_wen = 4'd0; data_sram_wdata = 32'd0;
    other_stall = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = 32'd0;
    #12;
    check("rst_req", 32'(mem_req), 32'd0);
    check("rst_wr", 32'(mem_wr), 32'd0);
    check("rst_strb", 32'(mem_wstrb), 32'd0);
    check("rst_addr", mem_addr, 32'd0);
    check("rst_wdata", mem_wdata, 32'd0);
    check("rst_rdata", data_sram_rdata, 32'd0);
    check("rst_stall", 32'(data_stall), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    idle(2);

    access(32'h0000_1000, 4'b0000, 32'h0000_0000, 32'hDEAD_BEEF, 0, 0, 0, 1'b0);
    access(32'h0000_2002, 4'b0011, 32'h0000_ABCD, 32'h1234_5678, 4, 0, 0, 1'b0);
    access(32'h0000_3000, 4'b0000, 32'h0000_0000, 32'hCAFE_F00D, 1, 2, 5, 1'b0);
    access(32'h0000_4000, 4'b0000, 32'h0000_0000, 32'h0BAD_F00D, 0, 1, 0, 1'b1);
    idle(3);
    access(32'h0000_5004, 4'b0000, 32'h0000_0000, 32'h0123_4567, 0, 0, 0, 1'b0);
    access(32'h0000_5008, 4'b1100, 32'h89AB_0000, 32'h7654_3210, 2, 1, 0, 1'b0);
    idle(1);

    // Reset while the request is waiting for mem_addr_ok.
    @(negedge clk);
    data_sram_en = 1'b1; data_sram_addr = 32'h0000_8000; data_sram_wen = 4'd0; data_sram_wdata = 32'd0;
    #1;
    check("rq_stall", 32'(data_stall), 32'd1);
    @(negedge clk);
    #1;
    check("addr_req", 32'(mem_req), 32'd1);
    @(negedge clk);
    rst = 1'b1; data_sram_en = 1'b0;
    #1;
    check("arst_req", 32'(mem_req), 32'd0);
    check("arst_rdata", data_sram_rdata, 32'd0);
    check("arst_stall", 32'(data_stall), 32'd0);
    check("arst_addr", mem_addr, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    idle(2);

    access(32'h0000_7000, 4'b1111, 32'h1122_3344, 32'h5566_7788, 0, 0, 0, 1'b0);
    idle(2);
    check("req_q_empty", 32'(req_q.size()), 32'd0);
    check("resp_q_empty", 32'(resp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
